dmem_banked: RTL and testbench
==============================

DMEM_BANKED -- requirements
Module: dmem_banked

Interface
REQ-001 The block SHALL have parameter DATA_W, 32, data word width in bits; a multiple of 8.
REQ-002 The block SHALL have parameter BANK_BITS, 3, bank-select width; NUM_BANKS = 2**BANK_BITS.
REQ-003 The block SHALL have parameter WORD_BITS, 10, word-index width; each bank holds 2**WORD_BITS words.
REQ-004 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-low reset.
REQ-006 The block SHALL have port req_valid, input, 1, request present.
REQ-007 The block SHALL have port req_ready, output, 1, request accepted this cycle when high with req_valid.
REQ-008 The block SHALL have port read_write, input, 1, 1 = write, 0 = read.
REQ-009 The block SHALL have port address, input, BANK_BITS+WORD_BITS; upper BANK_BITS select the bank, lower WORD_BITS the word.
REQ-010 The block SHALL have port data_in, input, DATA_W, write data.
REQ-011 The block SHALL have port byte_en, input, DATA_W/8, per-byte write enable; bit i covers data bits 8i+7:8i.
REQ-012 The block SHALL have port resp_valid, output, 1, read data valid.
REQ-013 The block SHALL have port resp_ready, input, 1, consumer accepts read data.
REQ-014 The block SHALL have port dataOut, output, DATA_W, read data.
REQ-015 The block SHALL have port init_done, output, 1, memory clear complete.

Function
REQ-016 The block SHALL implement two states: INIT and RUN.
REQ-017 In INIT, the block SHALL write zero to word init_cnt of every bank each cycle, incrementing init_cnt from 0; after word 2**WORD_BITS-1 it SHALL enter RUN on the next edge.
REQ-018 init_done SHALL be 0 in INIT and 1 in RUN; INIT SHALL last exactly 2**WORD_BITS cycles after reset deasserts.
REQ-019 req_ready SHALL be 0 in INIT; in RUN, req_ready = !resp_valid | resp_ready (combinational).
REQ-020 Accept = req_valid & req_ready; requests presented while req_ready is 0 SHALL be ignored, with no state change.
REQ-021 An accepted write SHALL update only the byte_en-selected bytes of the addressed word at the end of the accept cycle, produce no response, and leave resp_valid and dataOut unchanged.
REQ-022 A write with byte_en all zero SHALL leave memory unchanged.
REQ-023 A read accepted in cycle N SHALL assert resp_valid with dataOut = the addressed word in cycle N+1 (latency 1).
REQ-024 A read SHALL return data reflecting any write accepted in an earlier cycle, including the immediately preceding one.
REQ-025 While resp_valid=1 and resp_ready=0, resp_valid and dataOut SHALL hold stable.
REQ-026 When resp_valid=1 and resp_ready=1, the block SHALL load the next read's data in the same edge if a read is accepted; otherwise resp_valid SHALL clear.
REQ-027 With resp_ready held at 1, reads SHALL sustain one per cycle.
REQ-028 dataOut SHALL retain its last read value while resp_valid=0.
REQ-029 Accesses to different banks SHALL be fully independent; no aliasing between banks.

Reset
REQ-030 While reset=0 at a clock edge, the block SHALL set: state=INIT, init_cnt=0, req_ready=0, resp_valid=0, dataOut=0, init_done=0.
REQ-031 Reset asserted mid-operation SHALL drop any pending response and rerun the full INIT clear; contents written before reset SHALL read as 0 afterwards.

Verification
REQ-032 Hold reset=0 for 5 cycles, then release -> req_ready=0 and init_done=0 for exactly 1024 cycles, then both become 1; a read of bank 6, word 8 returns 0x00000000.
REQ-033 Write 0xA5A5A5A5 to bank 0, word 0 with byte_en=0xF, then read the same address -> resp_valid=1 one cycle after the read accept, with dataOut=0xA5A5A5A5.
REQ-034 Write 0x12345678 to bank 1, word 4, then write 0xFFFFFFFF to the same address with byte_en=0x5, then read it -> dataOut=0x12FF56FF.
REQ-035 Write 0x69420632 to bank 5, word 4 and 0x97319711 to bank 7, word 12 -> a read of bank 5, word 12 returns 0x00000000; a read of bank 7, word 12 returns 0x97319711; a read of bank 5, word 4 returns 0x69420632.
REQ-036 Read bank 5, word 4 with resp_ready=0 for 3 cycles -> resp_valid=1, dataOut=0x69420632 stable and req_ready=0 throughout; on resp_ready=1, the response completes and req_ready returns to 1.
REQ-037 Assert reset=0 for one cycle while resp_valid=1 -> resp_valid=0 on the next cycle, INIT reruns for 1024 cycles, and a subsequent read of bank 7, word 12 returns 0x00000000.

Source files
------------

// File: rtl/dmem_banked.sv
// ============================================================================
// Module   : dmem_banked
// Purpose  : Byte-writable banked data memory with a self-clearing INIT phase
//            and a one-deep, latency-1 read response buffer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_banked #(
  parameter int DATA_W    = 32,
  parameter int BANK_BITS = 3,
  parameter int WORD_BITS = 10
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           read_write,
  input  logic [BANK_BITS+WORD_BITS-1:0] address,
  input  logic [DATA_W-1:0]              data_in,
  input  logic [DATA_W/8-1:0]            byte_en,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [DATA_W-1:0]              dataOut,
  output logic                           init_done
);

  localparam int c_num_banks = 2 ** BANK_BITS;
  localparam int c_depth     = 2 ** WORD_BITS;
  localparam int c_bytes     = DATA_W / 8;
  localparam logic [WORD_BITS-1:0] c_last_word = '1;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [WORD_BITS-1:0]   init_cnt_q, init_cnt_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;

  logic                   w_accept;
  logic                   w_rd_acc;
  logic                   w_wr_acc;
  logic [BANK_BITS-1:0]   w_bank;
  logic [WORD_BITS-1:0]   w_word;
  logic [c_num_banks-1:0] w_we;
  logic [WORD_BITS-1:0]   w_idx;
  logic [DATA_W-1:0]      w_wdata;
  logic [c_bytes-1:0]     w_be;
  logic [DATA_W-1:0]      w_bank_rdata [c_num_banks];

  assign w_bank    = address[WORD_BITS +: BANK_BITS];
  assign w_word    = address[WORD_BITS-1:0];

  assign req_ready = (state_q == ST_RUN) && (!resp_valid_q || resp_ready);
  assign w_accept  = req_valid && req_ready;
  assign w_rd_acc  = w_accept && !read_write;
  assign w_wr_acc  = w_accept &&  read_write;

  assign resp_valid = resp_valid_q;
  assign dataOut    = rdata_q;
  assign init_done  = (state_q == ST_RUN);

  // INIT clears the same word index in every bank at once; RUN writes one bank.
  always_comb begin
    w_we    = '0;
    w_idx   = w_word;
    w_wdata = data_in;
    w_be    = byte_en;
    if (reset) begin
      if (state_q == ST_INIT) begin
        w_we    = '1;
        w_idx   = init_cnt_q;
        w_wdata = '0;
        w_be    = '1;
      end else if (w_wr_acc) begin
        w_we[w_bank] = 1'b1;
      end
    end
  end

  for (genvar b = 0; b < c_num_banks; b++) begin : g_bank
    logic [DATA_W-1:0] mem_q [c_depth];

    always_ff @(posedge clock) begin
      if (w_we[b]) begin
        for (int i = 0; i < c_bytes; i++) begin
          if (w_be[i]) begin
            mem_q[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
          end
        end
      end
    end

    assign w_bank_rdata[b] = mem_q[w_word];
  end

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    resp_valid_d = resp_valid_q;
    rdata_d      = rdata_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == c_last_word) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // A new read refills the buffer in the same edge the old one drains.
        if (w_rd_acc) begin
          resp_valid_d = 1'b1;
          rdata_d      = w_bank_rdata[w_bank];
        end else if (resp_valid_q && resp_ready) begin
          resp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_INIT;
      init_cnt_q   <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_banked.sv
// ============================================================================
// Module   : tb_dmem_banked
// Purpose  : Directed and randomized self-checking bench for dmem_banked.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmem_banked;

  logic        clock      = 1'b0;
  logic        reset      = 1'b0;
  logic        req_valid  = 1'b0;
  logic        req_ready;
  logic        read_write = 1'b0;
  logic [12:0] address    = '0;
  logic [31:0] data_in    = '0;
  logic [3:0]  byte_en    = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] dataOut;
  logic        init_done;

  int n_vec = 0;
  int n_err = 0;

  // Whole-memory shadow: index is bank*1024 + word
  logic [31:0] mdl [0:8191];

  always #5 clock = ~clock;

  dmem_banked #(.DATA_W(32), .BANK_BITS(3), .WORD_BITS(10)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .read_write (read_write),
    .address    (address),
    .data_in    (data_in),
    .byte_en    (byte_en),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .dataOut    (dataOut),
    .init_done  (init_done)
  );

  function automatic logic [12:0] ad(input int bank, input int word);
    return 13'(bank * 1024 + word);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  task automatic clk_step();
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    foreach (mdl[i]) mdl[i] = 32'h0;
  endtask

  // One request cycle; returns whether the DUT accepted it and updates the shadow.
  task automatic put_req(input logic rw, input logic [12:0] a, input logic [31:0] d,
                         input logic [3:0] be, output logic acc);
    req_valid  = 1'b1;
    read_write = rw;
    address    = a;
    data_in    = d;
    byte_en    = be;
    #2;
    acc = req_ready;
    if (acc && rw) mdl[a] = merge(mdl[a], d, be);
    clk_step();
    req_valid = 1'b0;
  endtask

  // Counts sampled cycles with init_done low; flags any req_ready seen high.
  task automatic wait_init(output int cyc, output logic bad_rdy);
    cyc     = 0;
    bad_rdy = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (init_done === 1'b1) break;
      if (req_ready !== 1'b0) bad_rdy = 1'b1;
      cyc++;
      clk_step();
    end
  endtask

  task automatic test_reset();
    int   cyc;
    logic bad;
    logic acc;
    reset = 1'b0; req_valid = 1'b1; read_write = 1'b1;
    address = ad(6, 8); data_in = 32'hDEADBEEF; byte_en = 4'hF;
    repeat (5) clk_step();
    n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    n_vec++; if (dataOut !== 32'h0) begin n_err++; $display("FAIL rst_dataOut: got %h want 0", dataOut); end
    n_vec++; if (init_done !== 1'b0) begin n_err++; $display("FAIL rst_init_done: got %b want 0", init_done); end
    req_valid = 1'b0;
    reset = 1'b1;
    model_clear();
    wait_init(cyc, bad);
    n_vec++; if (cyc != 1024) begin n_err++; $display("FAIL init_len: got %0d want 1024", cyc); end
    n_vec++; if (bad !== 1'b0) begin n_err++; $display("FAIL init_ready_low: got %b want 0", bad); end
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL run_req_ready: got %b want 1", req_ready); end
    put_req(1'b0, ad(6, 8), 32'h0, 4'h0, acc);
    n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL b6w8_acc: got %b want 1", acc); end
    n_vec++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL b6w8_valid: got %b want 1", resp_valid); end
    n_vec++; if (dataOut !== 32'h0) begin n_err++; $display("FAIL b6w8_data: got %h want 00000000", dataOut); end
  endtask

  task automatic test_full_write();
    logic acc;
    put_req(1'b1, ad(0, 0), 32'hA5A5A5A5, 4'hF, acc);
    n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL fw_acc: got %b want 1", acc); end
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL fw_no_resp: got %b want 0", resp_valid); end
    n_vec++; if (dataOut !== 32'h0) begin n_err++; $display("FAIL fw_data_kept: got %h want 00000000", dataOut); end
    put_req(1'b0, ad(0, 0), 32'h0, 4'h0, acc);
    n_vec++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL fw_rd_valid: got %b want 1", resp_valid); end
    n_vec++; if (dataOut !== 32'hA5A5A5A5) begin n_err++; $display("FAIL fw_rd_data: got %h want a5a5a5a5", dataOut); end
    clk_step();
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL fw_drain: got %b want 0", resp_valid); end
    n_vec++; if (dataOut !== 32'hA5A5A5A5) begin n_err++; $display("FAIL fw_retain: got %h want a5a5a5a5", dataOut); end
  endtask

  task automatic test_byte_enable();
    logic acc;
    put_req(1'b1, ad(1, 4), 32'h12345678, 4'hF, acc);
    put_req(1'b1, ad(1, 4), 32'hFFFFFFFF, 4'h5, acc);
    put_req(1'b1, ad(1, 4), 32'h00000000, 4'h0, acc);
    put_req(1'b0, ad(1, 4), 32'h0, 4'h0, acc);
    n_vec++; if (dataOut !== 32'h12FF56FF) begin n_err++; $display("FAIL be_merge: got %h want 12ff56ff", dataOut); end
    n_vec++; if (mdl[ad(1, 4)] !== 32'h12FF56FF) begin n_err++; $display("FAIL be_model: got %h want 12ff56ff", mdl[ad(1, 4)]); end
  endtask

  task automatic test_bank_independence();
    logic acc;
    put_req(1'b1, ad(5, 4),  32'h69420632, 4'hF, acc);
    put_req(1'b1, ad(7, 12), 32'h97319711, 4'hF, acc);
    put_req(1'b0, ad(5, 12), 32'h0, 4'h0, acc);
    n_vec++; if (dataOut !== 32'h0) begin n_err++; $display("FAIL bank_b5w12: got %h want 00000000", dataOut); end
    put_req(1'b0, ad(7, 12), 32'h0, 4'h0, acc);
    n_vec++; if (dataOut !== 32'h97319711) begin n_err++; $display("FAIL bank_b7w12: got %h want 97319711", dataOut); end
    put_req(1'b0, ad(5, 4), 32'h0, 4'h0, acc);
    n_vec++; if (dataOut !== 32'h69420632) begin n_err++; $display("FAIL bank_b5w4: got %h want 69420632", dataOut); end
    clk_step();
  endtask

  task automatic test_backpressure();
    logic acc;
    resp_ready = 1'b0;
    put_req(1'b0, ad(5, 4), 32'h0, 4'h0, acc);
    // A write presented while stalled must be ignored.
    for (int c = 0; c < 3; c++) begin
      req_valid = 1'b1; read_write = 1'b1; address = ad(5, 4);
      data_in = 32'h0; byte_en = 4'hF;
      #1;
      n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_c%0d: got %b want 0", c, req_ready); end
      n_vec++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_c%0d: got %b want 1", c, resp_valid); end
      n_vec++; if (dataOut !== 32'h69420632) begin n_err++; $display("FAIL bp_data_c%0d: got %h want 69420632", c, dataOut); end
      clk_step();
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    #1;
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_back: got %b want 1", req_ready); end
    clk_step();
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL bp_complete: got %b want 0", resp_valid); end
    put_req(1'b0, ad(5, 4), 32'h0, 4'h0, acc);
    n_vec++; if (dataOut !== 32'h69420632) begin n_err++; $display("FAIL bp_ignored_wr: got %h want 69420632", dataOut); end
  endtask

  task automatic test_back_to_back();
    logic        acc;
    logic [12:0] a;
    resp_ready = 1'b1;
    put_req(1'b1, ad(3, 100), 32'hCAFEF00D, 4'hF, acc);
    put_req(1'b0, ad(3, 100), 32'h0, 4'h0, acc);
    n_vec++; if (dataOut !== 32'hCAFEF00D) begin n_err++; $display("FAIL b2b_raw: got %h want cafef00d", dataOut); end
    for (int k = 0; k < 16; k++) begin
      a = ad($urandom_range(0, 7), (k % 2 == 0) ? 4 : 12);
      put_req(1'b0, a, 32'h0, 4'h0, acc);
      n_vec++;
      if (resp_valid !== 1'b1 || dataOut !== mdl[a]) begin
        n_err++;
        $display("FAIL b2b_rd_%0d: got v=%b d=%h want v=1 d=%h", k, resp_valid, dataOut, mdl[a]);
      end
    end
    clk_step();
  endtask

  task automatic test_random();
    logic        exp_rv;
    logic [31:0] exp_data;
    logic        exp_ready;
    logic        acc;
    exp_rv   = 1'b0;
    exp_data = 32'h0;
    for (int k = 0; k < 600; k++) begin
      req_valid  = 1'($urandom_range(0, 1));
      read_write = 1'($urandom_range(0, 1));
      address    = ad($urandom_range(0, 7), ($urandom_range(0, 9) == 0) ? 1023 : $urandom_range(0, 15));
      data_in    = $urandom;
      byte_en    = 4'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_ready = !exp_rv || resp_ready;
      n_vec++; if (req_ready !== exp_ready) begin n_err++; $display("FAIL rnd_ready_%0d: got %b want %b", k, req_ready, exp_ready); end
      n_vec++; if (resp_valid !== exp_rv) begin n_err++; $display("FAIL rnd_valid_%0d: got %b want %b", k, resp_valid, exp_rv); end
      if (exp_rv) begin
        n_vec++; if (dataOut !== exp_data) begin n_err++; $display("FAIL rnd_data_%0d: got %h want %h", k, dataOut, exp_data); end
      end
      acc = req_valid && exp_ready;
      if (acc && read_write) begin
        mdl[address] = merge(mdl[address], data_in, byte_en);
        if (exp_rv && resp_ready) exp_rv = 1'b0;
      end else if (acc) begin
        exp_rv   = 1'b1;
        exp_data = mdl[address];
      end else if (exp_rv && resp_ready) begin
        exp_rv = 1'b0;
      end
      clk_step();
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    clk_step();
  endtask

  task automatic test_mid_reset();
    int   cyc;
    logic bad;
    logic acc;
    resp_ready = 1'b0;
    put_req(1'b0, ad(7, 12), 32'h0, 4'h0, acc);
    n_vec++; if (resp_valid !== 1'b1 || dataOut !== mdl[ad(7, 12)]) begin
      n_err++; $display("FAIL mr_pre: got v=%b d=%h want v=1 d=%h", resp_valid, dataOut, mdl[ad(7, 12)]);
    end
    reset = 1'b0;
    clk_step();
    reset = 1'b1;
    model_clear();
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL mr_drop: got %b want 0", resp_valid); end
    n_vec++; if (init_done !== 1'b0) begin n_err++; $display("FAIL mr_init_done: got %b want 0", init_done); end
    n_vec++; if (dataOut !== 32'h0) begin n_err++; $display("FAIL mr_dataOut: got %h want 0", dataOut); end
    wait_init(cyc, bad);
    n_vec++; if (cyc != 1024) begin n_err++; $display("FAIL mr_init_len: got %0d want 1024", cyc); end
    n_vec++; if (bad !== 1'b0) begin n_err++; $display("FAIL mr_init_ready: got %b want 0", bad); end
    resp_ready = 1'b1;
    put_req(1'b0, ad(7, 12), 32'h0, 4'h0, acc);
    n_vec++; if (resp_valid !== 1'b1 || dataOut !== 32'h0) begin
      n_err++; $display("FAIL mr_cleared: got v=%b d=%h want v=1 d=00000000", resp_valid, dataOut);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_full_write();
    test_byte_enable();
    test_bank_independence();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
